// File: rtl/mult_8bit_seq.sv
// Shift-add multiplier reusing an external WIDTH-bit ripple adder.
// Optional MULT_ZERO_BYPASS_EN: zero operands skip CALC.
module mult_8bit_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_valid,
   output logic               start_ready,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic [WIDTH-1:0]   add_a,
   output logic [WIDTH-1:0]   add_b,
   output logic               add_cin,
   input  logic [WIDTH-1:0]   add_sum,
   input  logic               add_cout
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] lo;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] s;
   logic             c;
   logic             zero_op;

   assign start_ready = (state == IDLE);
   assign busy        = (state == CALC);
   assign res_valid   = (state == DONE);
   assign product     = res_valid ? {acc_hi, lo} : '0;

   assign add_a   = acc_hi;
   assign add_b   = lo[0] ? mcand : '0;
   assign add_cin = 1'b0;

   always_comb begin
      s = acc_hi;
      c = 1'b0;
      if (lo[0]) begin
         s = add_sum;
         c = add_cout;
      end
   end

`ifdef MULT_ZERO_BYPASS_EN
   assign zero_op = (op_a == '0) || (op_b == '0);
`else
   assign zero_op = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         acc_hi <= '0;
         lo     <= '0;
         cnt    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_valid) begin
                  mcand  <= op_a;
                  acc_hi <= '0;
                  cnt    <= '0;
                  if (zero_op) begin
                     lo    <= '0;
                     state <= DONE;
                  end else begin
                     lo    <= op_b;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               // carry lands in the top bit, so the shift never overflows
               {acc_hi, lo} <= {c, s, lo[WIDTH-1:1]};
               cnt          <= cnt + 1'b1;
               if (cnt == LAST) state <= DONE;
            end
            DONE: begin
               if (res_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_8bit_seq.sv
// Randomized and directed checks of mult_8bit_seq against a
// plain-arithmetic reference, with a behavioural adder attached.
module tb_mult_8bit_seq;

   logic        clk;
   logic        rst_n;
   logic        start_valid;
   logic        start_ready;
   logic [7:0]  op_a;
   logic [7:0]  op_b;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] product;
   logic        busy;
   logic [7:0]  add_a;
   logic [7:0]  add_b;
   logic        add_cin;
   logic [7:0]  add_sum;
   logic        add_cout;

   int n_cmp;
   int n_err;

   mult_8bit_seq #(.WIDTH(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start_valid(start_valid),
      .start_ready(start_ready),
      .op_a(op_a),
      .op_b(op_b),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .product(product),
      .busy(busy),
      .add_a(add_a),
      .add_b(add_b),
      .add_cin(add_cin),
      .add_sum(add_sum),
      .add_cout(add_cout)
   );

   // external ripple adder stand-in
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_ZERO_BYPASS_EN
      if (a == 8'd0 || b == 8'd0) return 0;
`endif
      return 8;
   endfunction

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input int hold, input string tag);
      int n;
      int bi;
      logic [15:0] exp;
      exp = 16'(a) * 16'(b);
      n = 0;
      bi = 0;
      res_ready = (hold == 0);
      @(negedge clk);
      chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
      start_valid = 1'b1;
      op_a = a;
      op_b = b;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      op_a = $urandom;
      op_b = $urandom;
      for (int k = 0; k < 20 && !res_valid; k++) begin
         if (busy) begin
            chk({tag, "_add_b"}, 32'(add_b), b[bi[2:0]] ? 32'(a) : 32'd0);
            bi++;
         end
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat(a, b)));
      chk({tag, "_busy_cycles"}, 32'(bi), 32'(exp_lat(a, b)));
      chk({tag, "_product"}, 32'(product), 32'(exp));
      for (int h = 0; h < hold; h++) begin
         start_valid = (h == 0);
         op_a = 8'h01;
         op_b = 8'h01;
         @(posedge clk);
         #1;
         chk({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
         chk({tag, "_hold_product"}, 32'(product), 32'(exp));
         chk({tag, "_hold_start_ready"}, 32'(start_ready), 32'd0);
      end
      start_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_after_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_after_ready"}, 32'(start_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      int n;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      start_valid = 1'b0;
      op_a = 8'd0;
      op_b = 8'd0;
      res_ready = 1'b1;
      #12;
      chk("rst_start_ready", 32'(start_ready), 32'd1);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_product", 32'(product), 32'd0);
      chk("rst_add_a", 32'(add_a), 32'd0);
      chk("rst_add_b", 32'(add_b), 32'd0);
      chk("rst_add_cin", 32'(add_cin), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(8'hFF, 8'hFF, 0, "ff_ff");
      run_op(8'h0D, 8'h0B, 0, "d_b");
      run_op(8'hA5, 8'h3C, 5, "a5_3c");
      run_op(8'h01, 8'h01, 0, "after_ignored");

      // asynchronous reset in the middle of CALC
      @(negedge clk);
      start_valid = 1'b1;
      op_a = 8'h37;
      op_b = 8'h59;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_res_valid", 32'(res_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_start_ready", 32'(start_ready), 32'd1);
      chk("arst_product", 32'(product), 32'd0);
      chk("arst_add_b", 32'(add_b), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h02, 8'h03, 0, "post_rst");

      run_op(8'h00, 8'h5A, 0, "zero_a");
      run_op(8'h5A, 8'h00, 1, "zero_b");

      // back-to-back with start_valid held high
      @(negedge clk);
      res_ready = 1'b1;
      start_valid = 1'b1;
      op_a = 8'h80;
      op_b = 8'h02;
      @(posedge clk);
      #1;
      op_a = 8'h01;
      op_b = 8'hFF;
      n = 0;
      for (int k = 0; k < 20 && !res_valid; k++) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("b2b_lat1", 32'(n), 32'd8);
      chk("b2b_prod1", 32'(product), 32'h0100);
      @(posedge clk);
      #1;
      chk("b2b_idle_ready", 32'(start_ready), 32'd1);
      chk("b2b_idle_valid", 32'(res_valid), 32'd0);
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      chk("b2b_second_busy", 32'(busy), 32'd1);
      n = 0;
      for (int k = 0; k < 20 && !res_valid; k++) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("b2b_lat2", 32'(n), 32'd8);
      chk("b2b_prod2", 32'(product), 32'h00FF);
      @(posedge clk);
      #1;
      chk("b2b_done", 32'(start_ready), 32'd1);

      for (int i = 0; i < 24; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (i % 8 == 3) ra = 8'd0;
         run_op(ra, rb, int'($urandom_range(0, 3)), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
